// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch timebase: FSM state encoding,
// seconds range constant and counter-width helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } sw_state_t;

    localparam int SEC_MAX = 59;

    // Bits needed to hold 0..range-1, never less than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a combinational wrap_pulse on the enabled
// cycle where the count reaches DIV-1; the count then reloads to zero.
module tick_prescaler #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap_pulse
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign wrap_pulse = en && !clr && (cnt == W'(DIV - 1));

    // Holding the count while disabled lets a resume finish the partial tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap_pulse ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: prescaled tick, sub/sec/min chain, run/pause/clear FSM.
// Lap capture is built only when STOPWATCH_LAP_CAPTURE_EN is defined.
module stopwatch_timebase
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ    = 10_000_000,
    parameter int TICK_HZ     = 100,
    parameter int MAX_MINUTES = 60,
    parameter int STOP_AT_MAX = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                stop,
    input  logic                                clear,
    input  logic                                lap,
    output logic                                running,
    output logic                                tick,
    output logic                                second_tick,
    output logic [cnt_width(TICK_HZ)-1:0]       sub_count,
    output logic [5:0]                          seconds,
    output logic [cnt_width(MAX_MINUTES)-1:0]   minutes,
    output logic                                overflow,
    output logic [cnt_width(TICK_HZ)-1:0]       lap_sub,
    output logic [5:0]                          lap_sec,
    output logic [cnt_width(MAX_MINUTES)-1:0]   lap_min,
    output logic                                lap_valid
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int SW  = cnt_width(TICK_HZ);
    localparam int MW  = cnt_width(MAX_MINUTES);

    sw_state_t      state, state_nxt;
    logic           adv;
    logic           sub_wrap, sec_wrap, at_max;
    logic           sec_tick_nxt, ovf_nxt;
    logic [SW-1:0]  sub_nxt;
    logic [5:0]     sec_nxt;
    logic [MW-1:0]  min_nxt;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .en         (state == RUNNING),
        .clr        (clear),
        .wrap_pulse (adv)
    );

    assign running  = (state == RUNNING);
    assign sub_wrap = (sub_count == SW'(TICK_HZ - 1));
    assign sec_wrap = (seconds == 6'(SEC_MAX));
    assign at_max   = sub_wrap && sec_wrap && (minutes == MW'(MAX_MINUTES - 1));

    always_comb begin
        sub_nxt      = sub_count;
        sec_nxt      = seconds;
        min_nxt      = minutes;
        sec_tick_nxt = 1'b0;
        ovf_nxt      = overflow;
        if (adv) begin
            if (at_max) begin
                ovf_nxt = 1'b1;
                // Halt mode freezes the counts at maximum; wrap mode rolls to zero.
                if (STOP_AT_MAX == 0) begin
                    sub_nxt      = '0;
                    sec_nxt      = '0;
                    min_nxt      = '0;
                    sec_tick_nxt = 1'b1;
                end
            end else if (sub_wrap) begin
                sub_nxt      = '0;
                sec_tick_nxt = 1'b1;
                if (sec_wrap) begin
                    sec_nxt = '0;
                    min_nxt = minutes + 1'b1;
                end else begin
                    sec_nxt = seconds + 1'b1;
                end
            end else begin
                sub_nxt = sub_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUNNING;
                RUNNING: begin
                    if (adv && at_max && (STOP_AT_MAX != 0)) state_nxt = DONE;
                    else if (stop)                           state_nxt = PAUSED;
                end
                PAUSED:  if (start) state_nxt = RUNNING;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sub_count   <= '0;
            seconds     <= '0;
            minutes     <= '0;
            tick        <= 1'b0;
            second_tick <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            sub_count   <= '0;
            seconds     <= '0;
            minutes     <= '0;
            tick        <= 1'b0;
            second_tick <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            sub_count   <= sub_nxt;
            seconds     <= sec_nxt;
            minutes     <= min_nxt;
            tick        <= adv;
            second_tick <= sec_tick_nxt;
            overflow    <= ovf_nxt;
        end
    end

`ifdef STOPWATCH_LAP_CAPTURE_EN
    // Snapshot takes the post-edge counts so a coinciding tick is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_sub   <= '0;
            lap_sec   <= '0;
            lap_min   <= '0;
            lap_valid <= 1'b0;
        end else if (clear) begin
            lap_sub   <= '0;
            lap_sec   <= '0;
            lap_min   <= '0;
            lap_valid <= 1'b0;
        end else begin
            lap_valid <= 1'b0;
            if (lap && (state == RUNNING || state == PAUSED)) begin
                lap_sub   <= sub_nxt;
                lap_sec   <= sec_nxt;
                lap_min   <= min_nxt;
                lap_valid <= 1'b1;
            end
        end
    end
`else
    assign lap_sub   = '0;
    assign lap_sec   = '0;
    assign lap_min   = '0;
    assign lap_valid = lap & 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Bench for stopwatch_timebase: a wrap-mode and a halt-mode instance driven
// in parallel, checked every cycle against an elapsed-tick reference model.
module tb_stopwatch_timebase;

  localparam int CLK_FREQ = 200;
  localparam int TICK_HZ  = 10;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int MAX_MIN  = 2;
  localparam int TOTAL    = MAX_MIN * 60 * TICK_HZ;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;

  logic       run_w, tick_w, stick_w, ovf_w, lv_w;
  logic [3:0] sub_w, lsub_w;
  logic [5:0] sec_w, lsec_w;
  logic [0:0] min_w, lmin_w;
  logic       run_h, tick_h, stick_h, ovf_h, lv_h;
  logic [3:0] sub_h, lsub_h;
  logic [5:0] sec_h, lsec_h;
  logic [0:0] min_h, lmin_h;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed tick count plus cycles spent inside current tick.
  int m_st[2], m_ph[2], m_el[2], m_ovf[2];
  int m_tick[2], m_stick[2], m_lapv[2], m_lsub[2], m_lsec[2], m_lmin[2];

  always #5 clk = ~clk;

  stopwatch_timebase #(
    .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .MAX_MINUTES(MAX_MIN), .STOP_AT_MAX(0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .running(run_w), .tick(tick_w), .second_tick(stick_w),
    .sub_count(sub_w), .seconds(sec_w), .minutes(min_w), .overflow(ovf_w),
    .lap_sub(lsub_w), .lap_sec(lsec_w), .lap_min(lmin_w), .lap_valid(lv_w)
  );

  stopwatch_timebase #(
    .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .MAX_MINUTES(MAX_MIN), .STOP_AT_MAX(1)
  ) dut_halt (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .running(run_h), .tick(tick_h), .second_tick(stick_h),
    .sub_count(sub_h), .seconds(sec_h), .minutes(min_h), .overflow(ovf_h),
    .lap_sub(lsub_h), .lap_sec(lsec_h), .lap_min(lmin_h), .lap_valid(lv_h)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_st[m] = M_IDLE; m_ph[m] = 0; m_el[m] = 0; m_ovf[m] = 0;
      m_tick[m] = 0; m_stick[m] = 0; m_lapv[m] = 0;
      m_lsub[m] = 0; m_lsec[m] = 0; m_lmin[m] = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit p, input bit c, input bit l);
    for (int m = 0; m < 2; m++) begin
      int old;
      bit halted;
      old = m_st[m];
      halted = 1'b0;
      m_tick[m] = 0; m_stick[m] = 0; m_lapv[m] = 0;
      if (c) begin
        m_st[m] = M_IDLE; m_ph[m] = 0; m_el[m] = 0; m_ovf[m] = 0;
        m_lsub[m] = 0; m_lsec[m] = 0; m_lmin[m] = 0;
      end else begin
        if (old == M_RUN) begin
          if (m_ph[m] == DIV - 1) begin
            m_ph[m] = 0;
            m_tick[m] = 1;
            if (m_el[m] == TOTAL - 1) begin
              m_ovf[m] = 1;
              if (m == 1) halted = 1'b1;
              else begin m_el[m] = 0; m_stick[m] = 1; end
            end else begin
              m_el[m]++;
              if (m_el[m] % TICK_HZ == 0) m_stick[m] = 1;
            end
          end else begin
            m_ph[m]++;
          end
        end
        if (old == M_RUN && halted)                    m_st[m] = M_DONE;
        else if (old == M_RUN && p)                    m_st[m] = M_PAUSE;
        else if ((old == M_IDLE || old == M_PAUSE) && s) m_st[m] = M_RUN;
`ifdef STOPWATCH_LAP_CAPTURE_EN
        if (l && (old == M_RUN || old == M_PAUSE)) begin
          m_lapv[m] = 1;
          m_lsub[m] = m_el[m] % TICK_HZ;
          m_lsec[m] = (m_el[m] / TICK_HZ) % 60;
          m_lmin[m] = m_el[m] / (TICK_HZ * 60);
        end
`else
        if (l) m_lapv[m] = 0;
`endif
      end
    end
  endtask

  task automatic check_dut(input int m, input string nm,
                           input logic rn, input logic tk, input logic stk,
                           input logic [31:0] sub, input logic [31:0] sec,
                           input logic [31:0] mins, input logic ovf, input logic lv,
                           input logic [31:0] ls, input logic [31:0] lsc,
                           input logic [31:0] lm);
    check({nm, ".running"},     rn,   (m_st[m] == M_RUN) ? 1 : 0);
    check({nm, ".tick"},        tk,   m_tick[m]);
    check({nm, ".second_tick"}, stk,  m_stick[m]);
    check({nm, ".sub_count"},   sub,  m_el[m] % TICK_HZ);
    check({nm, ".seconds"},     sec,  (m_el[m] / TICK_HZ) % 60);
    check({nm, ".minutes"},     mins, m_el[m] / (TICK_HZ * 60));
    check({nm, ".overflow"},    ovf,  m_ovf[m]);
    check({nm, ".lap_valid"},   lv,   m_lapv[m]);
    check({nm, ".lap_sub"},     ls,   m_lsub[m]);
    check({nm, ".lap_sec"},     lsc,  m_lsec[m]);
    check({nm, ".lap_min"},     lm,   m_lmin[m]);
  endtask

  task automatic check_all();
    check_dut(0, "wrap", run_w, tick_w, stick_w, sub_w, sec_w, min_w, ovf_w, lv_w,
              lsub_w, lsec_w, lmin_w);
    check_dut(1, "halt", run_h, tick_h, stick_h, sub_h, sec_h, min_h, ovf_h, lv_h,
              lsub_h, lsec_h, lmin_h);
  endtask

  // One clock edge with the given control pulses; outputs checked 1 ns later.
  task automatic step(input bit s, input bit p, input bit c, input bit l);
    start = s; stop = p; clear = c; lap = l;
    @(posedge clk);
    model_edge(s, p, c, l);
    #1;
    check_all();
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    bit s, p, c, l;

    // Reset state
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;

    // First tick exactly DIV edges after start
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(DIV - 1);
    check("first_tick_early", tick_w, 0);
    run(1);
    check("first_tick", tick_w, 1);
    check("first_sub", sub_w, 1);
    check("first_running", run_w, 1);

    // One full second
    run(DIV * TICK_HZ - DIV);
    check("one_sec_stick", stick_w, 1);
    check("one_sec_sec", sec_w, 1);
    check("one_sec_sub", sub_w, 0);

    // Pause keeps the partial tick
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run(50);
    check("paused_sub", sub_w, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(8);
    check("resume_no_tick", tick_w, 0);
    run(1);
    check("resume_tick", tick_w, 1);
    check("resume_sub", sub_w, 1);

    // Simultaneous clear+stop+start while running
    run(35);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("ccs_running", run_w, 0);
    check("ccs_sub", sub_w, 0);

    // Randomized control pulses
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 29) == 0);
      p = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 499) == 0);
      l = ($urandom_range(0, 24) == 0);
      step(s, p, c, l);
    end

    // Lap coinciding with the tick that makes 3.4 s
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(34 * DIV - 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef STOPWATCH_LAP_CAPTURE_EN
    check("lap_valid", lv_w, 1);
    check("lap_sec", lsec_w, 3);
    check("lap_sub", lsub_w, 4);
`else
    check("lap_valid_off", lv_w, 0);
`endif
    run(1);
    check("lap_pulse_end", lv_w, 0);
    check("lap_running", run_w, 1);

    // Run to maximum and one tick beyond
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(TOTAL * DIV - 1);
    check("pre_max_min", min_h, 1);
    check("pre_max_ovf", ovf_h, 0);
    run(1);
    check("wrap_sec", sec_w, 0);
    check("wrap_ovf", ovf_w, 1);
    check("wrap_running", run_w, 1);
    check("halt_min", min_h, 1);
    check("halt_sec", sec_h, 59);
    check("halt_sub", sub_h, TICK_HZ - 1);
    check("halt_tick", tick_h, 1);
    check("halt_running", run_h, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(DIV + 2);
    check("done_start_ignored", run_h, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("done_clear_ovf", ovf_h, 0);
    check("done_clear_sec", sec_h, 0);

    // Async reset mid-count at 37 s
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(37 * TICK_HZ * DIV);
    check("t37_sec", sec_w, 37);
    async_reset();
    check("rst_sec", sec_w, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run(DIV + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
